// File: rtl/handle_pool_arbiter_if.sv
// Request/grant, free, touch and status bundle shared by the requester agents
// and the handle pool arbiter.
interface handle_pool_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int NUM_HANDLES = 8,
  parameter int CNT_W       = 8
);
  localparam int REQ_W    = $clog2(NUM_REQ);
  localparam int HANDLE_W = $clog2(NUM_HANDLES);
  localparam int USE_W    = $clog2(NUM_HANDLES + 1);

  logic [NUM_REQ-1:0]  alloc_req;
  logic [NUM_REQ-1:0]  alloc_gnt;
  logic [HANDLE_W-1:0] alloc_handle;
  logic                free_valid;
  logic [HANDLE_W-1:0] free_handle;
  logic [REQ_W-1:0]    free_owner;
  logic                touch_valid;
  logic [HANDLE_W-1:0] touch_handle;
  logic                free_err;
  logic                leak_pulse;
  logic [HANDLE_W-1:0] leak_handle;
  logic [USE_W-1:0]    in_use_count;
  logic [CNT_W-1:0]    leak_count;
  logic                pool_empty;

  // Requester / resource-datapath side.
  modport master (
    output alloc_req, free_valid, free_handle, free_owner, touch_valid, touch_handle,
    input  alloc_gnt, alloc_handle, free_err, leak_pulse, leak_handle,
           in_use_count, leak_count, pool_empty
  );

  // Arbiter side.
  modport slave (
    input  alloc_req, free_valid, free_handle, free_owner, touch_valid, touch_handle,
    output alloc_gnt, alloc_handle, free_err, leak_pulse, leak_handle,
           in_use_count, leak_count, pool_empty
  );
endinterface

// File: rtl/handle_pool_arbiter.sv
// Handle pool manager: round-robin allocation of the lowest free handle,
// owner-checked frees, and a per-handle lease timer that reclaims leaked
// handles one per cycle (lowest index first).
module handle_pool_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int NUM_HANDLES   = 8,
  parameter int LEASE_TIMEOUT = 64,
  parameter int CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  handle_pool_arbiter_if.slave pool
);
  localparam int REQ_W    = $clog2(NUM_REQ);
  localparam int HANDLE_W = $clog2(NUM_HANDLES);
  localparam int USE_W    = $clog2(NUM_HANDLES + 1);
  localparam int LEASE_W  = $clog2(LEASE_TIMEOUT);
  localparam logic [LEASE_W-1:0] LEASE_LAST = LEASE_W'(LEASE_TIMEOUT - 1);

  // Per-handle state
  logic [NUM_HANDLES-1:0] alloc_q, alloc_d;
  logic [REQ_W-1:0]       owner_q [NUM_HANDLES];
  logic [REQ_W-1:0]       owner_d [NUM_HANDLES];
  logic [LEASE_W-1:0]     lease_q [NUM_HANDLES];
  logic [LEASE_W-1:0]     lease_d [NUM_HANDLES];

  // Arbiter and registered outputs
  logic [REQ_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [HANDLE_W-1:0] gnt_handle_q, gnt_handle_d;
  logic                free_err_q, free_err_d;
  logic                leak_pulse_q, leak_pulse_d;
  logic [HANDLE_W-1:0] leak_handle_q, leak_handle_d;
  logic [USE_W-1:0]    in_use_q, in_use_d;
  logic [CNT_W-1:0]    leak_cnt_q, leak_cnt_d;
  logic                pool_empty_q, pool_empty_d;

  logic [NUM_REQ-1:0]     eligible;
  logic                   win_found;
  logic [REQ_W-1:0]       win_idx;
  logic                   free_found;
  logic [HANDLE_W-1:0]    free_idx;
  logic                   grant;
  logic                   free_legal;
  logic [NUM_HANDLES-1:0] touch_hit, free_hit, expire, take, rel;
  logic                   leak_found;
  logic [HANDLE_W-1:0]    leak_idx;

  // Round-robin pick: first eligible requester at or after the pointer; the
  // previous grantee is masked because it is still dropping its request.
  always_comb begin
    eligible  = pool.alloc_req & ~gnt_q;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (eligible[REQ_W'((int'(rr_ptr_q) + k) % NUM_REQ)]) begin
        win_found = 1'b1;
        win_idx   = REQ_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  // Lowest-index FREE handle, taken from the pre-free pool state.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int h = NUM_HANDLES - 1; h >= 0; h--) begin
      if (!alloc_q[HANDLE_W'(h)]) begin
        free_found = 1'b1;
        free_idx   = HANDLE_W'(h);
      end
    end
  end

  assign grant      = win_found && free_found;
  assign free_legal = pool.free_valid && alloc_q[pool.free_handle] &&
                      (owner_q[pool.free_handle] == pool.free_owner);

  // Lowest expiring handle is reclaimed; the others hold at the last count.
  always_comb begin
    leak_found = 1'b0;
    leak_idx   = '0;
    for (int h = NUM_HANDLES - 1; h >= 0; h--) begin
      if (expire[HANDLE_W'(h)]) begin
        leak_found = 1'b1;
        leak_idx   = HANDLE_W'(h);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_HANDLES; gi++) begin : g_handle
    assign touch_hit[gi] = pool.touch_valid && alloc_q[gi] &&
                           (pool.touch_handle == HANDLE_W'(gi));
    assign free_hit[gi]  = free_legal && (pool.free_handle == HANDLE_W'(gi));
    assign expire[gi]    = alloc_q[gi] && (lease_q[gi] == LEASE_LAST) &&
                           !touch_hit[gi] && !free_hit[gi];
    assign take[gi]      = grant && (free_idx == HANDLE_W'(gi));
    assign rel[gi]       = free_hit[gi] || (leak_found && (leak_idx == HANDLE_W'(gi)));
    assign alloc_d[gi]   = take[gi] || (alloc_q[gi] && !rel[gi]);
    assign owner_d[gi]   = take[gi] ? win_idx : owner_q[gi];
    // A free or fresh/touched handle restarts its lease; an expired handle
    // waiting for its reclaim slot stays at the last count.
    assign lease_d[gi]   = (!alloc_d[gi] || take[gi] || touch_hit[gi]) ? '0 :
                           (lease_q[gi] == LEASE_LAST) ? lease_q[gi] :
                           lease_q[gi] + LEASE_W'(1);
  end

  // Status next-state: occupancy is recounted from the next pool state so
  // simultaneous alloc/free/leak always net out exactly.
  always_comb begin
    in_use_d = '0;
    for (int h = 0; h < NUM_HANDLES; h++) begin
      in_use_d = in_use_d + USE_W'(alloc_d[HANDLE_W'(h)]);
    end
    pool_empty_d  = &alloc_d;
    gnt_d         = grant ? (NUM_REQ'(1) << win_idx) : '0;
    gnt_handle_d  = grant ? free_idx : '0;
    rr_ptr_d      = !grant ? rr_ptr_q :
                    (win_idx == REQ_W'(NUM_REQ - 1)) ? '0 : win_idx + REQ_W'(1);
    free_err_d    = pool.free_valid && !free_legal;
    leak_pulse_d  = leak_found;
    leak_handle_d = leak_found ? leak_idx : '0;
    leak_cnt_d    = (leak_found && (leak_cnt_q != '1)) ? leak_cnt_q + CNT_W'(1) : leak_cnt_q;
  end

  // State and output registers; reset discards every lease silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_q       <= '0;
      owner_q       <= '{default: '0};
      lease_q       <= '{default: '0};
      rr_ptr_q      <= '0;
      gnt_q         <= '0;
      gnt_handle_q  <= '0;
      free_err_q    <= 1'b0;
      leak_pulse_q  <= 1'b0;
      leak_handle_q <= '0;
      in_use_q      <= '0;
      leak_cnt_q    <= '0;
      pool_empty_q  <= 1'b0;
    end else begin
      alloc_q       <= alloc_d;
      owner_q       <= owner_d;
      lease_q       <= lease_d;
      rr_ptr_q      <= rr_ptr_d;
      gnt_q         <= gnt_d;
      gnt_handle_q  <= gnt_handle_d;
      free_err_q    <= free_err_d;
      leak_pulse_q  <= leak_pulse_d;
      leak_handle_q <= leak_handle_d;
      in_use_q      <= in_use_d;
      leak_cnt_q    <= leak_cnt_d;
      pool_empty_q  <= pool_empty_d;
    end
  end

  assign pool.alloc_gnt    = gnt_q;
  assign pool.alloc_handle = gnt_handle_q;
  assign pool.free_err     = free_err_q;
  assign pool.leak_pulse   = leak_pulse_q;
  assign pool.leak_handle  = leak_handle_q;
  assign pool.in_use_count = in_use_q;
  assign pool.leak_count   = leak_cnt_q;
  assign pool.pool_empty   = pool_empty_q;
endmodule

// File: tb/tb_handle_pool_arbiter.sv
// Bench for handle_pool_arbiter: a table of alloc/free vectors checked through
// an expectation queue, plus hand-written lease/leak/reset sequences.
module tb_handle_pool_arbiter;
  localparam int NUM_REQ       = 4;
  localparam int NUM_HANDLES   = 8;
  localparam int LEASE_TIMEOUT = 64;
  localparam int CNT_W         = 8;
  localparam int NV            = 23;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  handle_pool_arbiter_if #(.NUM_REQ(NUM_REQ), .NUM_HANDLES(NUM_HANDLES), .CNT_W(CNT_W)) bus ();

  handle_pool_arbiter #(
    .NUM_REQ(NUM_REQ), .NUM_HANDLES(NUM_HANDLES),
    .LEASE_TIMEOUT(LEASE_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pool(bus)
  );

  typedef struct {
    logic [3:0] req;
    logic       fv;
    logic [2:0] fh;
    logic [1:0] fo;
    logic [3:0] gnt;
    logic [2:0] hnd;
    logic       ferr;
    logic [3:0] inuse;
    logic       empty;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [2:0] hnd;
    logic       ferr;
    logic [3:0] inuse;
    logic       empty;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb [$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic vec_t mk(input logic [3:0] req, input logic fv, input logic [2:0] fh,
                              input logic [1:0] fo, input logic [3:0] gnt, input logic [2:0] hnd,
                              input logic ferr, input logic [3:0] inuse, input logic empty);
    vec_t r;
    r.req = req; r.fv = fv; r.fh = fh; r.fo = fo;
    r.gnt = gnt; r.hnd = hnd; r.ferr = ferr; r.inuse = inuse; r.empty = empty;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_req    = '0;
    bus.free_valid   = 1'b0;
    bus.free_handle  = '0;
    bus.free_owner   = '0;
    bus.touch_valid  = 1'b0;
    bus.touch_handle = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " gnt"},         32'(bus.alloc_gnt),    32'(0));
    check({tag, " handle"},      32'(bus.alloc_handle), 32'(0));
    check({tag, " free_err"},    32'(bus.free_err),     32'(0));
    check({tag, " leak_pulse"},  32'(bus.leak_pulse),   32'(0));
    check({tag, " leak_handle"}, 32'(bus.leak_handle),  32'(0));
    check({tag, " in_use"},      32'(bus.in_use_count), 32'(0));
    check({tag, " leak_count"},  32'(bus.leak_count),   32'(0));
    check({tag, " pool_empty"},  32'(bus.pool_empty),   32'(0));
  endtask

  // Allocate handle 0 to requester 0 and handle 1 to requester 1 on
  // consecutive edges, optionally touching handle 0 on the second edge.
  task automatic alloc_two(input logic touch0);
    bus.alloc_req = 4'b0001;
    tick();
    check("seq gnt0", 32'(bus.alloc_gnt), 32'(4'b0001));
    check("seq hnd0", 32'(bus.alloc_handle), 32'(0));
    bus.alloc_req    = 4'b0010;
    bus.touch_valid  = touch0;
    bus.touch_handle = 3'd0;
    tick();
    check("seq gnt1", 32'(bus.alloc_gnt), 32'(4'b0010));
    check("seq hnd1", 32'(bus.alloc_handle), 32'(1));
    idle_inputs();
  endtask

  // Run from edge 2 to last_edge (edge 0 = first grant), expecting leaks of
  // handle 0 at edge e0 and handle 1 at edge e1.
  task automatic leak_watch(input int last_edge, input int e0, input int e1, input string tag);
    for (int e = 2; e <= last_edge; e++) begin
      tick();
      check({tag, " leak_pulse"}, 32'(bus.leak_pulse), 32'((e == e0) || (e == e1)));
      if (e == e0) begin
        check({tag, " leak_handle a"}, 32'(bus.leak_handle), 32'(0));
        check({tag, " in_use a"}, 32'(bus.in_use_count), 32'(1));
      end
      if (e == e1) check({tag, " leak_handle b"}, 32'(bus.leak_handle), 32'(1));
    end
    check({tag, " leak_count"}, 32'(bus.leak_count), 32'(2));
    check({tag, " in_use"}, 32'(bus.in_use_count), 32'(0));
    $display("%s: leaks expected at edges %0d/%0d, leak_count=%0d", tag, e0, e1, bus.leak_count);
  endtask

  initial begin
    exp_t e;
    //             req     fv  fh    fo     gnt     hnd  ferr inuse empty
    vecs[0]  = mk(4'b1111, 0, 3'd0, 2'd0, 4'b0001, 3'd0, 0, 4'd1, 0);
    vecs[1]  = mk(4'b1110, 0, 3'd0, 2'd0, 4'b0010, 3'd1, 0, 4'd2, 0);
    vecs[2]  = mk(4'b1100, 0, 3'd0, 2'd0, 4'b0100, 3'd2, 0, 4'd3, 0);
    vecs[3]  = mk(4'b1000, 0, 3'd0, 2'd0, 4'b1000, 3'd3, 0, 4'd4, 0);
    vecs[4]  = mk(4'b0000, 1, 3'd2, 2'd1, 4'b0000, 3'd0, 1, 4'd4, 0);
    vecs[5]  = mk(4'b0000, 1, 3'd7, 2'd0, 4'b0000, 3'd0, 1, 4'd4, 0);
    vecs[6]  = mk(4'b0000, 1, 3'd0, 2'd0, 4'b0000, 3'd0, 0, 4'd3, 0);
    vecs[7]  = mk(4'b0001, 0, 3'd0, 2'd0, 4'b0001, 3'd0, 0, 4'd4, 0);
    vecs[8]  = mk(4'b0000, 1, 3'd0, 2'd0, 4'b0000, 3'd0, 0, 4'd3, 0);
    vecs[9]  = mk(4'b0001, 0, 3'd0, 2'd0, 4'b0001, 3'd0, 0, 4'd4, 0);
    vecs[10] = mk(4'b0010, 0, 3'd0, 2'd0, 4'b0010, 3'd4, 0, 4'd5, 0);
    vecs[11] = mk(4'b0100, 0, 3'd0, 2'd0, 4'b0100, 3'd5, 0, 4'd6, 0);
    vecs[12] = mk(4'b1000, 0, 3'd0, 2'd0, 4'b1000, 3'd6, 0, 4'd7, 0);
    vecs[13] = mk(4'b0001, 0, 3'd0, 2'd0, 4'b0001, 3'd7, 0, 4'd8, 1);
    vecs[14] = mk(4'b0010, 0, 3'd0, 2'd0, 4'b0000, 3'd0, 0, 4'd8, 1);
    vecs[15] = mk(4'b0010, 1, 3'd5, 2'd2, 4'b0000, 3'd0, 0, 4'd7, 0);
    vecs[16] = mk(4'b0010, 0, 3'd0, 2'd0, 4'b0010, 3'd5, 0, 4'd8, 1);
    vecs[17] = mk(4'b0000, 1, 3'd5, 2'd0, 4'b0000, 3'd0, 1, 4'd8, 1);
    vecs[18] = mk(4'b0100, 1, 3'd5, 2'd1, 4'b0000, 3'd0, 0, 4'd7, 0);
    vecs[19] = mk(4'b0100, 0, 3'd0, 2'd0, 4'b0100, 3'd5, 0, 4'd8, 1);
    vecs[20] = mk(4'b0000, 1, 3'd3, 2'd3, 4'b0000, 3'd0, 0, 4'd7, 0);
    vecs[21] = mk(4'b1000, 1, 3'd1, 2'd1, 4'b1000, 3'd3, 0, 4'd7, 0);
    vecs[22] = mk(4'b0000, 0, 3'd0, 2'd0, 4'b0000, 3'd0, 0, 4'd7, 0);

    // Reset state
    do_reset();
    check_all_zero("reset");
    $display("reset: all outputs checked");

    // Table-driven alloc/free vectors
    for (int i = 0; i < NV; i++) begin
      bus.alloc_req   = vecs[i].req;
      bus.free_valid  = vecs[i].fv;
      bus.free_handle = vecs[i].fh;
      bus.free_owner  = vecs[i].fo;
      e.gnt = vecs[i].gnt; e.hnd = vecs[i].hnd; e.ferr = vecs[i].ferr;
      e.inuse = vecs[i].inuse; e.empty = vecs[i].empty;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      check($sformatf("vec%0d gnt", i), 32'(bus.alloc_gnt), 32'(e.gnt));
      if (e.gnt != 4'b0000) check($sformatf("vec%0d handle", i), 32'(bus.alloc_handle), 32'(e.hnd));
      check($sformatf("vec%0d free_err", i), 32'(bus.free_err), 32'(e.ferr));
      check($sformatf("vec%0d in_use", i), 32'(bus.in_use_count), 32'(e.inuse));
      check($sformatf("vec%0d pool_empty", i), 32'(bus.pool_empty), 32'(e.empty));
      check($sformatf("vec%0d leak_pulse", i), 32'(bus.leak_pulse), 32'(0));
      $display("vec %0d: req=%b free=%b/%0d/%0d -> gnt=%b hnd=%0d err=%b in_use=%0d empty=%b",
               i, vecs[i].req, vecs[i].fv, vecs[i].fh, vecs[i].fo,
               bus.alloc_gnt, bus.alloc_handle, bus.free_err, bus.in_use_count, bus.pool_empty);
    end
    idle_inputs();

    // Two untouched handles leak on consecutive cycles
    do_reset();
    alloc_two(1'b0);
    leak_watch(67, LEASE_TIMEOUT, LEASE_TIMEOUT + 1, "leak seq");

    // Two handles expire in the same cycle: second one waits a cycle
    do_reset();
    alloc_two(1'b1);
    leak_watch(68, LEASE_TIMEOUT + 1, LEASE_TIMEOUT + 2, "dual expiry");

    // Periodic touches keep the lease alive; a free in the expiry cycle wins
    do_reset();
    bus.alloc_req = 4'b0001;
    tick();
    check("touch gnt", 32'(bus.alloc_gnt), 32'(4'b0001));
    bus.alloc_req = '0;
    for (int i = 1; i <= 300; i++) begin
      bus.touch_valid  = (i % 30 == 0);
      bus.touch_handle = 3'd0;
      tick();
      check("touch leak_pulse", 32'(bus.leak_pulse), 32'(0));
    end
    bus.touch_valid = 1'b0;
    for (int j = 1; j < LEASE_TIMEOUT; j++) begin
      tick();
      check("pre-expiry leak_pulse", 32'(bus.leak_pulse), 32'(0));
    end
    check("pre-expiry in_use", 32'(bus.in_use_count), 32'(1));
    bus.free_valid  = 1'b1;
    bus.free_handle = 3'd0;
    bus.free_owner  = 2'd0;
    tick();
    idle_inputs();
    check("expiry free leak_pulse", 32'(bus.leak_pulse), 32'(0));
    check("expiry free free_err", 32'(bus.free_err), 32'(0));
    check("expiry free in_use", 32'(bus.in_use_count), 32'(0));
    check("expiry free leak_count", 32'(bus.leak_count), 32'(0));
    tick();
    check("post free leak_pulse", 32'(bus.leak_pulse), 32'(0));
    $display("touch seq: 300 touched cycles, free at expiry, leak_count=%0d", bus.leak_count);

    // Reset in the middle of live leases
    do_reset();
    alloc_two(1'b0);
    repeat (20) tick();
    check("mid in_use before reset", 32'(bus.in_use_count), 32'(2));
    rst_n = 1'b0;
    #1;
    check_all_zero("mid-reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      check("after reset leak_pulse", 32'(bus.leak_pulse), 32'(0));
    end
    check("after reset leak_count", 32'(bus.leak_count), 32'(0));
    $display("mid-lease reset: outputs cleared, no leak afterwards");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
